cacheline_adaptor: RTL and testbench
====================================

// Module: cacheline_adaptor
// PURPOSE
//  Physical-memory-side responder to the cache datapath's pmem port. Accepts one
//  256-bit line read or write (pmem_read/pmem_write, pmem_address) and services
//  it as a 4-beat x 64-bit burst on main memory. Returns the assembled line with a
//  one-cycle pmem_resp. Sits between the cache and the burst memory/arbiter.
// PARAMETERS
//  LINE_W   256  cache line width in bits
//  BURST_W  64   memory beat width in bits
//  BEATS    LINE_W/BURST_W (4)  beats per line; derived, not overridden
// PORTS
//  clk          in   1        clock; all state updates on rising edge
//  rst          in   1        synchronous reset, active-high
//  pmem_read    in   1        cache line read request; held until pmem_resp
//  pmem_write   in   1        cache line write request; held until pmem_resp
//  pmem_address in   32       line address from cache
//  pmem_wdata   in   LINE_W   line to write
//  pmem_rdata   out  LINE_W   assembled read line
//  pmem_resp    out  1        request complete, exactly one cycle
//  mem_read     out  1        burst read to memory
//  mem_write    out  1        burst write to memory
//  mem_address  out  32       line-aligned burst address
//  mem_wdata    out  BURST_W  current write beat
//  mem_rdata    in   BURST_W  current read beat
//  mem_resp     in   1        beat accepted/valid this cycle
// BEHAVIOUR
//  Reset: state IDLE, beat count 0, mem_read/mem_write/pmem_resp 0, mem_address 0,
//   mem_wdata 0, pmem_rdata 0. Reset mid-burst abandons the burst with no pmem_resp;
//   memory model is reset alongside.
//  FSM: IDLE, RD_BURST, WR_BURST, DONE.
//  IDLE: pmem_write high -> latch address {pmem_address[31:5],5'b0} and pmem_wdata,
//   beat=0, go WR_BURST. Else pmem_read high -> latch address, beat=0, go RD_BURST.
//   Both high: write wins (writeback precedes fill); read is served on the next
//   accept if still held.
//  RD_BURST: mem_read=1, mem_address=latched. Each cycle mem_resp=1: store mem_rdata
//   into bits [beat*64 +: 64] of the line buffer, beat++. On beat BEATS-1 go DONE;
//   mem_read drops the cycle after the last beat. Beats need not be consecutive;
//   mem_resp=0 cycles stall with no change.
//  WR_BURST: mem_write=1, mem_wdata=line[beat*64 +: 64]. Each mem_resp=1 advances
//   beat; on beat BEATS-1 acked go DONE.
//  DONE: pmem_resp=1 one cycle; pmem_rdata = assembled line (reads) and holds its
//   value until the next read completes; go IDLE unconditionally. pmem_read/write
//   sampled in DONE are ignored (no re-accept).
//  Latency: request at cycle 0 (IDLE), mem_read/mem_write from cycle 1; pmem_resp
//   the cycle after the final mem_resp. Min read/write latency 6 cycles.
//  pmem_read/pmem_write/pmem_address/pmem_wdata ignored outside IDLE; mem_resp
//   ignored in IDLE/DONE. Beat counter is log2(BEATS) bits, no wrap past BEATS-1.
//  Requester must deassert pmem_read/pmem_write no later than the cycle after
//   pmem_resp.
// STRUCTURE
//  cache_pkg: LINE_W/BURST_W/BEATS localparams, adaptor_state_t enum
//   {IDLE,RD_BURST,WR_BURST,DONE}. Single module, no sub-module; state register,
//   beat counter, address/line buffers, one always_comb for outputs/next state.
// TESTING
//  1 Read @0x0000_1234, mem beats 0x11..,0x22..,0x33..,0x44.. back-to-back ->
//    mem_address=0x0000_1220, pmem_rdata={0x44..,0x33..,0x22..,0x11..}, one resp.
//  2 Write line 0xDEAD..BEEF @0x8000_0040 -> mem_wdata beats low-to-high 64b,
//    4 mem_resp, pmem_resp one cycle after 4th, mem_write low afterward.
//  3 Read with mem_resp gaps (1,0,0,1,1,0,1) -> correct line, resp after 4th beat.
//  4 pmem_read and pmem_write high together -> write burst first, then read burst;
//    two pmem_resp pulses.
//  5 rst asserted after beat 2 of a read -> next cycle IDLE, mem_read=0, no
//    pmem_resp; fresh read then completes correctly.
//  6 Spurious mem_resp in IDLE and pmem_read held through DONE -> no state change,
//    no second burst.

Source files
------------

// File: rtl/cacheline_adaptor_pkg.sv
// Shared widths, beat helpers and FSM state type for the cacheline adaptor.
// No ports; imported by the interfaces and the adaptor.
package cacheline_adaptor_pkg;

    localparam int LINE_W  = 256;
    localparam int BURST_W = 64;
    localparam int BEATS   = LINE_W / BURST_W;
    localparam int BEAT_W  = $clog2(BEATS);

    typedef logic [BEAT_W-1:0] beat_t;

    localparam beat_t LAST_BEAT = beat_t'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RD_BURST,
        WR_BURST,
        DONE
    } adaptor_state_t;

    // Bit offset of a beat inside the line.
    function automatic int unsigned beat_lsb(beat_t b);
        return int'(b) * BURST_W;
    endfunction

endpackage

// File: rtl/cacheline_adaptor_if.sv
// Cache-side line port (pmem_if) and memory-side burst port (mem_if).
// master drives requests, slave responds.
interface pmem_if;
    import cacheline_adaptor_pkg::*;

    logic              pmem_read;
    logic              pmem_write;
    logic [31:0]       pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;

    modport master (
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );

    modport slave (
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp
    );
endinterface

interface mem_if;
    import cacheline_adaptor_pkg::*;

    logic               mem_read;
    logic               mem_write;
    logic [31:0]        mem_address;
    logic [BURST_W-1:0] mem_wdata;
    logic [BURST_W-1:0] mem_rdata;
    logic               mem_resp;

    modport master (
        output mem_read, mem_write, mem_address, mem_wdata,
        input  mem_rdata, mem_resp
    );

    modport slave (
        input  mem_read, mem_write, mem_address, mem_wdata,
        output mem_rdata, mem_resp
    );
endinterface

// File: rtl/cacheline_adaptor.sv
// Turns one 256-bit cache line read/write into a 4 x 64-bit memory burst.
// Ports: clk, rst (sync, active-high), pmem (cache side), mem (burst side).
module cacheline_adaptor
    import cacheline_adaptor_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    pmem_if.slave  pmem,
    mem_if.master  mem
);

    adaptor_state_t     state_q;
    beat_t              beat_q;
    logic [31:0]        addr_q;
    logic [LINE_W-1:0]  line_q;
    logic [LINE_W-1:0]  rdata_q;
    logic [BURST_W-1:0] wdata_q;
    logic               rd_q;
    logic               wr_q;
    logic               resp_q;

    logic [LINE_W-1:0]  fill;
    beat_t              beat_nx;

    // Line buffer with the current read beat merged in.
    always_comb begin
        fill = line_q;
        fill[beat_lsb(beat_q) +: BURST_W] = mem.mem_rdata;
        beat_nx = beat_q + beat_t'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            addr_q  <= '0;
            line_q  <= '0;
            rdata_q <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            resp_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    beat_q <= '0;
                    // Writeback wins so a dirty victim leaves before the fill.
                    if (pmem.pmem_write) begin
                        addr_q  <= pmem.pmem_address & ~32'h1f;
                        line_q  <= pmem.pmem_wdata;
                        wdata_q <= pmem.pmem_wdata[BURST_W-1:0];
                        wr_q    <= 1'b1;
                        state_q <= WR_BURST;
                    end else if (pmem.pmem_read) begin
                        addr_q  <= pmem.pmem_address & ~32'h1f;
                        rd_q    <= 1'b1;
                        state_q <= RD_BURST;
                    end
                end
                RD_BURST: begin
                    if (mem.mem_resp) begin
                        line_q <= fill;
                        if (beat_q == LAST_BEAT) begin
                            rdata_q <= fill;
                            rd_q    <= 1'b0;
                            resp_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            beat_q <= beat_nx;
                        end
                    end
                end
                WR_BURST: begin
                    if (mem.mem_resp) begin
                        if (beat_q == LAST_BEAT) begin
                            wr_q    <= 1'b0;
                            resp_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            beat_q  <= beat_nx;
                            wdata_q <= line_q[beat_lsb(beat_nx) +: BURST_W];
                        end
                    end
                end
                DONE: begin
                    resp_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pmem.pmem_rdata = rdata_q;
    assign pmem.pmem_resp  = resp_q;
    assign mem.mem_read    = rd_q;
    assign mem.mem_write   = wr_q;
    assign mem.mem_address = addr_q;
    assign mem.mem_wdata   = wdata_q;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed + randomized bench for cacheline_adaptor.
// Line-level reference: expected lines are built from the beats handed out.
module tb_cacheline_adaptor;
    import cacheline_adaptor_pkg::*;

    logic clk = 1'b0;
    logic rst;

    pmem_if pmem ();
    mem_if  mem ();

    cacheline_adaptor dut (
        .clk  (clk),
        .rst  (rst),
        .pmem (pmem),
        .mem  (mem)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    logic [LINE_W-1:0] last_rd = '0;

    task automatic chk(string tag, logic [LINE_W-1:0] obs,
                       logic [LINE_W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Starts and ends on a falling edge with the adaptor idle.
    // pat bit i = mem_resp in burst cycle i (1 after bit 15).
    // abort>0: reset after that many beats. hold: keep pmem_read through DONE.
    task automatic do_read(logic [31:0] addr, logic [15:0] pat,
                           bit fixed, int abort, bit hold);
        logic [LINE_W-1:0] exp;
        logic [BURST_W-1:0] b;
        int got;
        int i;
        bit r;
        exp = '0;
        got = 0;
        i = 0;
        pmem.pmem_read = 1'b1;
        pmem.pmem_address = addr;
        @(negedge clk);
        chk("rd_addr", LINE_W'(mem.mem_address), LINE_W'(addr & ~32'h1f));
        while (got < BEATS && i < 64) begin
            if (abort > 0 && got == abort) break;
            r = (i < 16) ? pat[i] : 1'b1;
            chk("rd_mem_read", LINE_W'(mem.mem_read), LINE_W'(1));
            chk("rd_no_resp", LINE_W'(pmem.pmem_resp), LINE_W'(0));
            if (fixed) b = 64'h1111_1111_1111_1111 * 64'(got + 1);
            else b = {$urandom, $urandom};
            mem.mem_rdata = b;
            mem.mem_resp = r;
            if (r) begin
                exp[got*BURST_W +: BURST_W] = b;
                got++;
            end
            @(negedge clk);
            i++;
        end
        mem.mem_resp = 1'b0;
        if (abort > 0) begin
            rst = 1'b1;
            pmem.pmem_read = 1'b0;
            @(negedge clk);
            rst = 1'b0;
            chk("rst_mem_read", LINE_W'(mem.mem_read), LINE_W'(0));
            chk("rst_resp", LINE_W'(pmem.pmem_resp), LINE_W'(0));
            chk("rst_rdata", pmem.pmem_rdata, '0);
            chk("rst_addr", LINE_W'(mem.mem_address), LINE_W'(0));
            last_rd = '0;
            @(negedge clk);
            chk("rst_idle", LINE_W'(mem.mem_read), LINE_W'(0));
            return;
        end
        chk("rd_beats", LINE_W'(got), LINE_W'(BEATS));
        chk("rd_resp", LINE_W'(pmem.pmem_resp), LINE_W'(1));
        chk("rd_line", pmem.pmem_rdata, exp);
        chk("rd_drop", LINE_W'(mem.mem_read), LINE_W'(0));
        last_rd = exp;
        if (!hold) pmem.pmem_read = 1'b0;
        mem.mem_resp = hold;
        @(negedge clk);
        chk("rd_resp_once", LINE_W'(pmem.pmem_resp), LINE_W'(0));
        chk("rd_hold_line", pmem.pmem_rdata, exp);
        pmem.pmem_read = 1'b0;
        @(negedge clk);
        mem.mem_resp = 1'b0;
        chk("rd_no_reaccept", LINE_W'(mem.mem_read), LINE_W'(0));
        chk("rd_idle_resp", LINE_W'(pmem.pmem_resp), LINE_W'(0));
    endtask

    // keep_rd: pmem_read is also high and stays high after the write.
    task automatic do_write(logic [31:0] addr, logic [LINE_W-1:0] line,
                            logic [15:0] pat, bit keep_rd);
        int got;
        int i;
        bit r;
        got = 0;
        i = 0;
        pmem.pmem_write = 1'b1;
        pmem.pmem_read = keep_rd;
        pmem.pmem_address = addr;
        pmem.pmem_wdata = line;
        @(negedge clk);
        chk("wr_addr", LINE_W'(mem.mem_address), LINE_W'(addr & ~32'h1f));
        chk("wr_not_read", LINE_W'(mem.mem_read), LINE_W'(0));
        while (got < BEATS && i < 64) begin
            r = (i < 16) ? pat[i] : 1'b1;
            chk("wr_mem_write", LINE_W'(mem.mem_write), LINE_W'(1));
            chk("wr_beat", LINE_W'(mem.mem_wdata),
                LINE_W'(line[got*BURST_W +: BURST_W]));
            mem.mem_resp = r;
            if (r) got++;
            @(negedge clk);
            i++;
        end
        mem.mem_resp = 1'b0;
        chk("wr_resp", LINE_W'(pmem.pmem_resp), LINE_W'(1));
        chk("wr_drop", LINE_W'(mem.mem_write), LINE_W'(0));
        chk("wr_rdata_kept", pmem.pmem_rdata, last_rd);
        pmem.pmem_write = 1'b0;
        @(negedge clk);
        chk("wr_resp_once", LINE_W'(pmem.pmem_resp), LINE_W'(0));
        chk("wr_idle", LINE_W'(mem.mem_write), LINE_W'(0));
    endtask

    initial begin
        rst = 1'b1;
        pmem.pmem_read = 1'b0;
        pmem.pmem_write = 1'b0;
        pmem.pmem_address = '0;
        pmem.pmem_wdata = '0;
        mem.mem_rdata = '0;
        mem.mem_resp = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_read", LINE_W'(mem.mem_read), LINE_W'(0));
        chk("reset_write", LINE_W'(mem.mem_write), LINE_W'(0));
        chk("reset_resp", LINE_W'(pmem.pmem_resp), LINE_W'(0));
        chk("reset_addr", LINE_W'(mem.mem_address), LINE_W'(0));
        chk("reset_wdata", LINE_W'(mem.mem_wdata), LINE_W'(0));
        chk("reset_rdata", pmem.pmem_rdata, '0);
        rst = 1'b0;
        @(negedge clk);

        do_read(32'h0000_1234, 16'hffff, 1'b1, 0, 1'b0);
        do_write(32'h8000_0040,
                 {64'hDEAD_4444_4444_BEEF, 64'hDEAD_3333_3333_BEEF,
                  64'hDEAD_2222_2222_BEEF, 64'hDEAD_1111_1111_BEEF},
                 16'hffff, 1'b0);
        do_read(32'h0000_2f00, 16'b1011001, 1'b0, 0, 1'b0);

        do_write(32'h0000_3000, {8{$urandom}}, 16'hffff, 1'b1);
        do_read(32'h0000_3000, 16'hffff, 1'b0, 0, 1'b0);

        do_read(32'h0000_4444, 16'hffff, 1'b0, 2, 1'b0);
        do_read(32'h0000_5555, 16'hffff, 1'b0, 0, 1'b0);

        mem.mem_resp = 1'b1;
        @(negedge clk);
        mem.mem_resp = 1'b0;
        chk("idle_spurious_rd", LINE_W'(mem.mem_read), LINE_W'(0));
        chk("idle_spurious_wr", LINE_W'(mem.mem_write), LINE_W'(0));
        chk("idle_spurious_resp", LINE_W'(pmem.pmem_resp), LINE_W'(0));
        do_read(32'h0000_6660, 16'hffff, 1'b0, 0, 1'b1);

        for (int n = 0; n < 12; n++) begin
            logic [31:0] a;
            logic [15:0] p;
            a = $urandom;
            p = 16'($urandom);
            if ($urandom_range(0, 1) == 1)
                do_read(a, p, 1'b0, 0, 1'($urandom_range(0, 1)));
            else
                do_write(a, {8{$urandom}}, p, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
